// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM256x64 access controller:
// default widths, FSM state encoding and requester port id.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 64;

  // One request in flight: accept in IDLE, drive the RAM in ACCESS,
  // collect registered read data in RESP.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester id: port 0 is the CPU data side, port 1 the loader/DMA side.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant selector for the RAM access controller.
// Build option: RAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (last served port loses a tie); otherwise port 0 has fixed priority.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  port_t      last_port,
  output port_t      grant
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Tie goes to the port that was not served last; a lone requester wins.
  always_comb begin
    grant = PORT0;
    if (valid[0] && valid[1]) begin
      grant = (last_port == PORT0) ? PORT1 : PORT0;
    end else if (valid[1]) begin
      grant = PORT1;
    end
  end
`else
  // Fixed priority has no use for the service history.
  logic unused_last_port;
  assign unused_last_port = last_port;

  // Port 1 only wins when port 0 is not asking.
  always_comb begin
    grant = PORT0;
    if (!valid[0] && valid[1]) begin
      grant = PORT1;
    end
  end
`endif

endmodule

// File: rtl/ram256x64_arbiter.sv
// Two-requester access controller for a RAM256x64 (registered read).
// Serialises one request at a time onto the RAM port and returns a
// one-cycle response pulse per port. Arbitration policy is chosen by
// the RAM_ARB_ROUND_ROBIN_EN build macro inside ram_arb_pick.
module ram256x64_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_wrt,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_t            state_reg, state_next;
  port_t             grant;
  port_t             port_reg;
  port_t             last_port_reg;
  logic              accept;
  logic              sel_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rsp_fire;
  logic [DATA_W-1:0] rsp_data;

  ram_arb_pick u_pick (
    .valid     ({req1_valid, req0_valid}),
    .last_port (last_port_reg),
    .grant     (grant)
  );

  assign sel_valid = (grant == PORT1) ? req1_valid : req0_valid;
  assign sel_we    = (grant == PORT1) ? req1_we    : req0_we;
  assign sel_addr  = (grant == PORT1) ? req1_addr  : req0_addr;
  assign sel_wdata = (grant == PORT1) ? req1_wdata : req0_wdata;

  assign req0_ready = (state_reg == IDLE) && (grant == PORT0);
  assign req1_ready = (state_reg == IDLE) && (grant == PORT1);
  assign accept     = (state_reg == IDLE) && sel_valid;

  // A write completes at the end of ACCESS (ack carries zero data);
  // a read completes at the end of RESP with the RAM's registered output.
  assign rsp_fire = ((state_reg == ACCESS) && ram_wrt) || (state_reg == RESP);
  assign rsp_data = (state_reg == RESP) ? ram_data_out : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; ram_wrt doubles as the latched write flag in ACCESS.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  state_next = ram_wrt ? IDLE : RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the accepted request straight into the RAM-side registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_reg    <= PORT0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      ram_wrt     <= 1'b0;
    end else if (accept) begin
      port_reg    <= grant;
      ram_addr    <= sel_addr;
      ram_data_in <= sel_wdata;
      ram_wrt     <= sel_we;
    end else if (state_reg == ACCESS) begin
      ram_wrt     <= 1'b0;
    end
  end

  // Remember the last served port; reset value lets port 0 win first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_port_reg <= PORT1;
    end else if (accept) begin
      last_port_reg <= grant;
    end
  end

  // Response pulses and sticky per-port read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (rsp_fire) begin
        if (port_reg == PORT0) begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= rsp_data;
        end else begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= rsp_data;
        end
      end
    end
  end

endmodule

// File: doc/ram256x64_arbiter.md
# ram256x64_arbiter

Two-requester access controller for the RAM256x64 block (256 words x 64 bits, write on posedge `clk` when `wrt`=1, registered read). It arbitrates between two requesters over a valid/ready request handshake, serialises their accesses onto the single RAM port, and returns read data or a write acknowledge on a per-requester response pulse. It sits between the core-side requesters (port 0: CPU data, port 1: loader/DMA) and one RAM256x64 instance.

## Interface
- `ADDR_W`, 8, RAM address width
- `DATA_W`, 64, RAM word width
- `clk`  in  1  system clock, all logic on posedge
- `rst`  in  1  asynchronous, active-high reset
- `req0_valid` / `req1_valid`  in  1  request present
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid & ready
- `req0_we` / `req1_we`  in  1  1 = write, 0 = read
- `req0_addr` / `req1_addr`  in  ADDR_W  word address
- `req0_wdata` / `req1_wdata`  in  DATA_W  write data
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle completion pulse (read data or write ack)
- `rsp0_rdata` / `rsp1_rdata`  out  DATA_W  read data, 0 for write acks
- `ram_addr`  out  ADDR_W  to RAM `addr`
- `ram_data_in`  out  DATA_W  to RAM `data_in`
- `ram_wrt`  out  1  to RAM `wrt`
- `ram_data_out`  in  DATA_W  from RAM `data_out`

## Operation
- FSM states: IDLE, ACCESS, RESP. One request in flight at a time.
- IDLE: grant selector picks one valid requester; `reqN_ready` = (state==IDLE) & (grant==N), combinational. On acceptance latch port id, we, addr, wdata -> ACCESS. No valid requester -> stay IDLE.
- ACCESS: `ram_addr`/`ram_data_in`/`ram_wrt` are registered and stable for the whole cycle; `ram_wrt`=latched we. Write: RAM writes at the end-of-ACCESS edge; same edge sets `rspN_valid`=1, `rspN_rdata`=0; -> IDLE. Read: -> RESP, `ram_wrt`=0.
- RESP: at end-of-RESP edge capture `ram_data_out` into `rspN_rdata`, set `rspN_valid`=1; -> IDLE.
- `rspN_valid` is high for exactly one cycle; `rspN_rdata` holds its value until the next response on that port.
- Requesters must hold valid/we/addr/wdata stable until accepted. Non-granted requests wait; no drop.
- `ram_wrt` is 0 in every state except ACCESS-with-write. `ram_addr` holds its last value outside ACCESS.
- Reset (asynchronous, any state): state=IDLE, `ram_wrt`=0, `ram_addr`=0, `ram_data_in`=0, both `rspN_valid`=0, both `rspN_rdata`=0, round-robin pointer favours port 0. In-flight request discarded, no response issued; a write interrupted in ACCESS must not complete.

## Timing
- Acceptance edge = E. Write: RAM updated at E+1, `rsp_valid` high in cycle after E+1. Read: RAM address sampled at E+1, `rsp_valid` and data in cycle after E+2.
- Throughput: one write per 2 cycles, one read per 3 cycles. A new request may be accepted in the same cycle a response pulse is high.
- Simultaneous `req0_valid` & `req1_valid` in IDLE: only one granted per the configured policy.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined: round-robin; pointer records last-served port, updated on acceptance; with both valid, the port not last served wins; after reset port 0 wins first.
- Not defined: fixed priority, port 0 always wins over port 1; no pointer register.

## Structure
- Package `ram_arb_pkg`: `ADDR_W`/`DATA_W` defaults, FSM state enum (IDLE, ACCESS, RESP), port-id type.
- Sub-module `ram_arb_pick`: combinational grant selector (valid bits + pointer -> grant); contains the only `RAM_ARB_ROUND_ROBIN_EN` conditional logic.

## Test plan
- Reset asserted mid-ACCESS of write {addr 8'h10, data 64'hDEAD_BEEF_0000_0001} -> `ram_wrt` drops immediately, no rsp, later read of 8'h10 returns prior content.
- Port 0 writes 64'h0123_4567_89AB_CDEF to 8'h05, then reads 8'h05 -> rsp0 write ack 2 cycles after acceptance, read data 64'h0123_4567_89AB_CDEF 3 cycles after acceptance.
- Port 1 fills all 256 addresses with addr-derived data, then reads 8'hFF and 8'h00 -> correct data, address 8'hFF does not wrap or corrupt 8'h00.
- Both ports hold reads continuously, macro undefined -> port 0 granted every time, port 1 starves.
- Same stimulus, `RAM_ARB_ROUND_ROBIN_EN` defined -> grants alternate 0,1,0,1 starting with port 0.
- Port 0 write and port 1 read of same address 8'h42 raised simultaneously (fixed priority) -> port 1 read returns port 0's written data.
